// File: rtl/axil_mem_port_master_pkg.sv
// Shared definitions for the AXI4-Lite to memory-port bridge.
// MMIO word addresses are shared with firmware and the memory wrapper.
package axil_mem_port_master_pkg;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam logic [9:0] MMIO_MATCH   = 10'h200;
    localparam logic [9:0] MMIO_PASS    = 10'h201;
    localparam logic [9:0] MMIO_FILTER  = 10'h202;
    localparam logic [9:0] MMIO_PWM     = 10'h203;
    localparam logic [9:0] MMIO_CNT_RST = 10'h204;
    localparam logic [9:0] MMIO_CORE_RST = 10'h205;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ISSUE,
        S_WR_RESP,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_RD_RESP
    } state_t;

endpackage

// File: rtl/axil_wr_capture.sv
// Independent AW/W holding registers with ready generation.
// o_complete also counts handshakes happening this cycle.
module axil_wr_capture
    import axil_mem_port_master_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int STRB_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_clr,
    input  logic [ADDR_WIDTH-1:0] i_awaddr,
    input  logic                  i_awvalid,
    output logic                  o_awready,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [STRB_WIDTH-1:0] i_wstrb,
    input  logic                  i_wvalid,
    output logic                  o_wready,
    output logic                  o_empty,
    output logic                  o_complete,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [STRB_WIDTH-1:0] o_strb
);

    logic                  r_aw_full;
    logic                  r_w_full;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic [STRB_WIDTH-1:0] r_strb;
    logic                  w_aw_hs;
    logic                  w_w_hs;

    assign o_awready = i_en & ~r_aw_full;
    assign o_wready  = i_en & ~r_w_full;
    assign w_aw_hs   = i_awvalid & o_awready;
    assign w_w_hs    = i_wvalid & o_wready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_strb    <= '0;
        end else if (i_clr) begin
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_aw_full <= 1'b1;
                r_addr    <= i_awaddr;
            end
            if (w_w_hs) begin
                r_w_full <= 1'b1;
                r_data   <= i_wdata;
                r_strb   <= i_wstrb;
            end
        end
    end

    assign o_empty    = ~r_aw_full & ~r_w_full;
    assign o_complete = (r_aw_full | w_aw_hs) & (r_w_full | w_w_hs);
    assign o_addr     = r_aw_full ? r_addr : i_awaddr;
    assign o_data     = r_w_full ? r_data : i_wdata;
    assign o_strb     = r_w_full ? r_strb : i_wstrb;

endmodule

// File: rtl/axil_mem_port_master.sv
// AXI4-Lite slave driving one initiator port of the data-memory wrapper.
// Address is held through the read window since MMIO reads decode it live.
module axil_mem_port_master
    import axil_mem_port_master_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int BYTE_WIDTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [ADDR_WIDTH+1:0]            i_s_awaddr,
    input  logic                             i_s_awvalid,
    output logic                             o_s_awready,
    input  logic [DATA_WIDTH-1:0]            i_s_wdata,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] i_s_wstrb,
    input  logic                             i_s_wvalid,
    output logic                             o_s_wready,
    output logic [1:0]                       o_s_bresp,
    output logic                             o_s_bvalid,
    input  logic                             i_s_bready,
    input  logic [ADDR_WIDTH+1:0]            i_s_araddr,
    input  logic                             i_s_arvalid,
    output logic                             o_s_arready,
    output logic [DATA_WIDTH-1:0]            o_s_rdata,
    output logic [1:0]                       o_s_rresp,
    output logic                             o_s_rvalid,
    input  logic                             i_s_rready,
    output logic                             o_m_ce,
    output logic [DATA_WIDTH/BYTE_WIDTH-1:0] o_m_we,
    output logic [ADDR_WIDTH-1:0]            o_m_addr,
    output logic [DATA_WIDTH-1:0]            o_m_data_out,
    input  logic [DATA_WIDTH-1:0]            i_m_data_in
);

    localparam int SW = DATA_WIDTH / BYTE_WIDTH;
    localparam logic [1:0] LAST_CNT = 2'(READ_LATENCY - 1);

    state_t                r_state;
    state_t                w_next;
    logic                  r_prio_rd;
    logic [1:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_m_addr;
    logic [DATA_WIDTH-1:0] r_m_data;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_idle;
    logic                  w_empty;
    logic                  w_wr_go;
    logic                  w_clr;
    logic                  w_ar_hs;
    logic                  w_contend;
    logic                  w_rd_last;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [SW-1:0]         w_wr_strb;
    logic                  w_unused;

    assign w_unused = ^{i_s_awaddr[1:0], i_s_araddr[1:0]};

    // Readies stay low while reset is held, not just after the first edge.
    assign w_idle = (r_state == S_IDLE) & ~i_rst;
    assign w_clr  = (r_state == S_WR_RESP) & i_s_bready;

    axil_wr_capture #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .STRB_WIDTH (SW)
    ) u_wr_capture (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_en       (w_idle),
        .i_clr      (w_clr),
        .i_awaddr   (i_s_awaddr[ADDR_WIDTH+1:2]),
        .i_awvalid  (i_s_awvalid),
        .o_awready  (o_s_awready),
        .i_wdata    (i_s_wdata),
        .i_wstrb    (i_s_wstrb),
        .i_wvalid   (i_s_wvalid),
        .o_wready   (o_s_wready),
        .o_empty    (w_empty),
        .o_complete (w_wr_go),
        .o_addr     (w_wr_addr),
        .o_data     (w_wr_data),
        .o_strb     (w_wr_strb)
    );

    assign o_s_arready = w_idle & w_empty & (~w_wr_go | r_prio_rd);
    assign w_ar_hs     = i_s_arvalid & o_s_arready;
    assign w_contend   = w_idle & w_empty & w_wr_go & i_s_arvalid;
    assign w_rd_last   = (r_cnt == LAST_CNT);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_ar_hs)      w_next = S_RD_ISSUE;
                else if (w_wr_go) w_next = S_WR_ISSUE;
            end
            S_WR_ISSUE: w_next = S_WR_RESP;
            S_WR_RESP:  if (i_s_bready) w_next = S_IDLE;
            S_RD_ISSUE: w_next = S_RD_WAIT;
            S_RD_WAIT:  if (w_rd_last) w_next = S_RD_RESP;
            S_RD_RESP:  if (i_s_rready) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_m_ce     = 1'b0;
        o_m_we     = '0;
        o_s_bvalid = 1'b0;
        o_s_rvalid = 1'b0;
        unique case (r_state)
            S_WR_ISSUE: begin
                o_m_ce = 1'b1;
                o_m_we = w_wr_strb;
            end
            S_RD_ISSUE: o_m_ce     = 1'b1;
            S_WR_RESP:  o_s_bvalid = 1'b1;
            S_RD_RESP:  o_s_rvalid = 1'b1;
            default:    o_m_ce     = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prio_rd <= 1'b0;
            r_cnt     <= '0;
            r_m_addr  <= '0;
            r_m_data  <= '0;
            r_rdata   <= '0;
        end else begin
            if (r_state == S_IDLE) begin
                if (w_ar_hs) begin
                    r_m_addr <= i_s_araddr[ADDR_WIDTH+1:2];
                end else if (w_wr_go) begin
                    r_m_addr <= w_wr_addr;
                    r_m_data <= w_wr_data;
                end
                if (w_contend) r_prio_rd <= ~r_prio_rd;
            end
            if (r_state == S_RD_ISSUE)     r_cnt <= '0;
            else if (r_state == S_RD_WAIT) r_cnt <= r_cnt + 2'd1;
            if (r_state == S_RD_WAIT && w_rd_last) r_rdata <= i_m_data_in;
        end
    end

    assign o_m_addr     = r_m_addr;
    assign o_m_data_out = r_m_data;
    assign o_s_rdata    = r_rdata;
    assign o_s_bresp    = RESP_OKAY;
    assign o_s_rresp    = RESP_OKAY;

endmodule

// File: tb/tb_axil_mem_port_master.sv
// Directed bench for the AXI4-Lite memory-port bridge.
// Inputs change and outputs are sampled around the falling edge.
module tb_axil_mem_port_master;
    import axil_mem_port_master_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [11:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        m_ce;
    logic [3:0]  m_we;
    logic [9:0]  m_addr;
    logic [31:0] m_dout;
    logic [31:0] m_din;

    logic [31:0] mem [0:1023];
    logic [31:0] r_q;
    int          n_ce = 0;
    int          n_ce0;
    int          n_assert = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    axil_mem_port_master dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_s_awaddr   (awaddr),
        .i_s_awvalid  (awvalid),
        .o_s_awready  (awready),
        .i_s_wdata    (wdata),
        .i_s_wstrb    (wstrb),
        .i_s_wvalid   (wvalid),
        .o_s_wready   (wready),
        .o_s_bresp    (bresp),
        .o_s_bvalid   (bvalid),
        .i_s_bready   (bready),
        .i_s_araddr   (araddr),
        .i_s_arvalid  (arvalid),
        .o_s_arready  (arready),
        .o_s_rdata    (rdata),
        .o_s_rresp    (rresp),
        .o_s_rvalid   (rvalid),
        .i_s_rready   (rready),
        .o_m_ce       (m_ce),
        .o_m_we       (m_we),
        .o_m_addr     (m_addr),
        .o_m_data_out (m_dout),
        .i_m_data_in  (m_din)
    );

    // One-cycle-latency RAM; the match counter decodes the live address.
    always @(posedge clk) begin
        if (m_ce) begin
            for (int b = 0; b < 4; b++)
                if (m_we[b]) mem[m_addr][8*b +: 8] <= m_dout[8*b +: 8];
            r_q  <= mem[m_addr];
            n_ce <= n_ce + 1;
        end
    end

    assign m_din = (m_addr == MMIO_MATCH) ? 32'h12345678 : r_q;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0;
        bready = 0; araddr = '0; arvalid = 0; rready = 0;
        nxt(); nxt();
        #1;
        chk("rst_awready", {31'b0, awready}, 32'd0);
        chk("rst_wready", {31'b0, wready}, 32'd0);
        chk("rst_arready", {31'b0, arready}, 32'd0);
        chk("rst_bvalid", {31'b0, bvalid}, 32'd0);
        chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
        chk("rst_ce", {31'b0, m_ce}, 32'd0);
        chk("rst_we", {28'b0, m_we}, 32'd0);
        chk("rst_addr", {22'b0, m_addr}, 32'd0);
        chk("rst_dout", m_dout, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        nxt();
        rst = 1'b0;
        #1;
        chk("idle_arready", {31'b0, arready}, 32'd1);

        // Write 0xDEADBEEF to 0x010 with AW and W together
        awaddr = 12'h010; awvalid = 1; wdata = 32'hDEADBEEF;
        wstrb = 4'hF; wvalid = 1;
        #1;
        chk("t1_awready", {31'b0, awready}, 32'd1);
        chk("t1_wready", {31'b0, wready}, 32'd1);
        nxt();
        awvalid = 0; wvalid = 0;
        chk("t1_ce", {31'b0, m_ce}, 32'd1);
        chk("t1_we", {28'b0, m_we}, 32'hF);
        chk("t1_addr", {22'b0, m_addr}, 32'h004);
        chk("t1_dout", m_dout, 32'hDEADBEEF);
        chk("t1_bvalid_early", {31'b0, bvalid}, 32'd0);
        nxt();
        chk("t1_ce_off", {31'b0, m_ce}, 32'd0);
        chk("t1_we_off", {28'b0, m_we}, 32'd0);
        chk("t1_bvalid", {31'b0, bvalid}, 32'd1);
        chk("t1_bresp", {30'b0, bresp}, 32'd0);
        bready = 1;
        nxt();
        bready = 0;
        chk("t1_bdone", {31'b0, bvalid}, 32'd0);

        // Read it back: RVALID three cycles after AR
        araddr = 12'h010; arvalid = 1;
        #1;
        chk("t1_arready", {31'b0, arready}, 32'd1);
        nxt();
        arvalid = 0;
        chk("t1r_ce", {31'b0, m_ce}, 32'd1);
        chk("t1r_we", {28'b0, m_we}, 32'd0);
        chk("t1r_addr", {22'b0, m_addr}, 32'h004);
        chk("t1r_rv1", {31'b0, rvalid}, 32'd0);
        nxt();
        chk("t1r_rv2", {31'b0, rvalid}, 32'd0);
        chk("t1r_ce2", {31'b0, m_ce}, 32'd0);
        nxt();
        chk("t1r_rvalid", {31'b0, rvalid}, 32'd1);
        chk("t1r_rdata", rdata, 32'hDEADBEEF);
        chk("t1r_rresp", {30'b0, rresp}, 32'd0);
        rready = 1;
        nxt();
        rready = 0;
        chk("t1r_rdone", {31'b0, rvalid}, 32'd0);

        // W four cycles before AW, PWM register
        wdata = 32'h0000007F; wstrb = 4'hF; wvalid = 1;
        #1;
        chk("t2_wready", {31'b0, wready}, 32'd1);
        nxt();
        wvalid = 0;
        n_ce0 = n_ce;
        chk("t2_wfull", {31'b0, wready}, 32'd0);
        chk("t2_awready", {31'b0, awready}, 32'd1);
        araddr = 12'h010; arvalid = 1;
        #1;
        chk("t2_partial_blocks_ar", {31'b0, arready}, 32'd0);
        arvalid = 0;
        nxt(); nxt(); nxt();
        chk("t2_no_ce", n_ce - n_ce0, 32'd0);
        awaddr = 12'h80C; awvalid = 1;
        #1;
        chk("t2_aw_hs", {31'b0, awready}, 32'd1);
        nxt();
        awvalid = 0;
        chk("t2_ce", {31'b0, m_ce}, 32'd1);
        chk("t2_addr", {22'b0, m_addr}, 32'h203);
        chk("t2_dout", m_dout, 32'h7F);
        nxt();
        chk("t2_bvalid", {31'b0, bvalid}, 32'd1);
        chk("t2_bresp", {30'b0, bresp}, 32'd0);
        chk("t2_one_ce", n_ce - n_ce0, 32'd1);
        bready = 1;
        nxt();
        bready = 0;

        // Match counter read, address held through the window
        araddr = 12'h800; arvalid = 1;
        nxt();
        arvalid = 0;
        chk("t3_addr_issue", {22'b0, m_addr}, 32'h200);
        nxt();
        chk("t3_addr_wait", {22'b0, m_addr}, 32'h200);
        nxt();
        chk("t3_rvalid", {31'b0, rvalid}, 32'd1);
        chk("t3_rdata", rdata, 32'h12345678);
        chk("t3_addr_resp", {22'b0, m_addr}, 32'h200);
        rready = 1;
        nxt();
        rready = 0;

        // Contention twice: write wins, then read wins
        awaddr = 12'h020; wdata = 32'h11111111; wstrb = 4'hF;
        awvalid = 1; wvalid = 1; araddr = 12'h010; arvalid = 1;
        #1;
        chk("t4_arready_1", {31'b0, arready}, 32'd0);
        nxt();
        awvalid = 0; wvalid = 0;
        chk("t4_wr_ce", {31'b0, m_ce}, 32'd1);
        chk("t4_wr_we", {28'b0, m_we}, 32'hF);
        chk("t4_wr_addr", {22'b0, m_addr}, 32'h008);
        nxt();
        chk("t4_bvalid", {31'b0, bvalid}, 32'd1);
        bready = 1;
        nxt();
        bready = 0;
        awaddr = 12'h024; wdata = 32'h22222222; awvalid = 1; wvalid = 1;
        #1;
        chk("t4_arready_2", {31'b0, arready}, 32'd1);
        nxt();
        awvalid = 0; wvalid = 0; arvalid = 0;
        chk("t4_rd_ce", {31'b0, m_ce}, 32'd1);
        chk("t4_rd_we", {28'b0, m_we}, 32'd0);
        chk("t4_rd_addr", {22'b0, m_addr}, 32'h004);
        nxt();
        chk("t4_rd_wait_ce", {31'b0, m_ce}, 32'd0);
        nxt();
        chk("t4_rvalid", {31'b0, rvalid}, 32'd1);
        chk("t4_rdata", rdata, 32'hDEADBEEF);
        rready = 1;
        nxt();
        rready = 0;
        chk("t4_gap_ce", {31'b0, m_ce}, 32'd0);
        nxt();
        chk("t4_wr2_ce", {31'b0, m_ce}, 32'd1);
        chk("t4_wr2_addr", {22'b0, m_addr}, 32'h009);
        chk("t4_wr2_dout", m_dout, 32'h22222222);
        nxt();
        chk("t4_bvalid2", {31'b0, bvalid}, 32'd1);
        bready = 1;
        nxt();
        bready = 0;

        // RREADY held low: response stable, nothing accepted
        araddr = 12'h024; arvalid = 1;
        nxt();
        arvalid = 0;
        nxt(); nxt();
        awaddr = 12'h030; awvalid = 1; wvalid = 1; arvalid = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t5_rvalid", {31'b0, rvalid}, 32'd1);
            chk("t5_rdata", rdata, 32'h22222222);
            chk("t5_awready", {31'b0, awready}, 32'd0);
            chk("t5_wready", {31'b0, wready}, 32'd0);
            chk("t5_arready", {31'b0, arready}, 32'd0);
            nxt();
        end
        awvalid = 0; wvalid = 0; arvalid = 0; rready = 1;
        nxt();
        rready = 0;
        chk("t5_rdone", {31'b0, rvalid}, 32'd0);
        chk("t5_aw_not_taken", {31'b0, awready}, 32'd1);
        chk("t5_w_not_taken", {31'b0, wready}, 32'd1);

        // Reset during the read wait
        araddr = 12'h010; arvalid = 1;
        nxt();
        arvalid = 0;
        chk("t6_ce", {31'b0, m_ce}, 32'd1);
        nxt();
        rst = 1;
        #1;
        chk("t6_rst_rvalid", {31'b0, rvalid}, 32'd0);
        chk("t6_rst_ce", {31'b0, m_ce}, 32'd0);
        chk("t6_rst_we", {28'b0, m_we}, 32'd0);
        chk("t6_rst_addr", {22'b0, m_addr}, 32'd0);
        chk("t6_rst_rdata", rdata, 32'd0);
        nxt();
        chk("t6_no_resp", {31'b0, rvalid}, 32'd0);
        rst = 0;
        araddr = 12'h80C; arvalid = 1;
        #1;
        chk("t6_arready", {31'b0, arready}, 32'd1);
        nxt();
        arvalid = 0;
        nxt(); nxt();
        chk("t6_rvalid", {31'b0, rvalid}, 32'd1);
        chk("t6_rdata", rdata, 32'h7F);
        rready = 1;
        nxt();
        rready = 0;
        chk("t6_rdone", {31'b0, rvalid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/axil_mem_port_master.md
Name: axil_mem_port_master

Overview:
- AXI4-Lite slave to single-port memory-initiator bridge: host/PS-side transactions become ce/we/addr/data cycles on one port of the data-memory wrapper (RAM below 0x200, MMIO registers match/pass/filter count, PWM width, counter reset, core reset at 0x200-0x205).
- Drives the port as its initiator, so the host can load RISC-V data memory, poll counters and release core reset.
- Holds the address stable through the read-latency window, because the MMIO read mux decodes the live address.

Parameters:
- DATA_WIDTH, 32, AXI data and memory word width.
- ADDR_WIDTH, 10, memory word-address width; AXI byte address is ADDR_WIDTH+2 bits.
- BYTE_WIDTH, 8, bits per write-enable lane.
- READ_LATENCY, 1, cycles from ce to valid read data (1..3).

Ports:
- i_clk  in  1  sole clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_s_awaddr  in  ADDR_WIDTH+2  write byte address.
- i_s_awvalid  in  1  AW valid.
- o_s_awready  out  1  AW ready.
- i_s_wdata  in  DATA_WIDTH  write data.
- i_s_wstrb  in  DATA_WIDTH/BYTE_WIDTH  byte strobes.
- i_s_wvalid  in  1  W valid.
- o_s_wready  out  1  W ready.
- o_s_bresp  out  2  always 2'b00.
- o_s_bvalid  out  1  B valid.
- i_s_bready  in  1  B ready.
- i_s_araddr  in  ADDR_WIDTH+2  read byte address.
- i_s_arvalid  in  1  AR valid.
- o_s_arready  out  1  AR ready.
- o_s_rdata  out  DATA_WIDTH  read data.
- o_s_rresp  out  2  always 2'b00.
- o_s_rvalid  out  1  R valid.
- i_s_rready  in  1  R ready.
- o_m_ce  out  1  memory chip enable.
- o_m_we  out  DATA_WIDTH/BYTE_WIDTH  byte write enables.
- o_m_addr  out  ADDR_WIDTH  word address.
- o_m_data_out  out  DATA_WIDTH  write data to memory.
- i_m_data_in  in  DATA_WIDTH  read data from memory.

Behaviour:
- Reset (async assert, sync release):
  - all valid/ready low, o_m_ce=0, o_m_we=0, o_m_addr=0, o_m_data_out=0, o_s_rdata=0.
  - AW/W holding latches empty, state IDLE, arbitration priority = write.
- Word address = byte_addr[ADDR_WIDTH+1:2]; bits [1:0] ignored, no alignment error. Every access responds OKAY, including unmapped MMIO.
- FSM states: IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_WAIT, RD_RESP.
- IDLE, write-channel acceptance:
  - o_s_awready=1 while AW latch empty; o_s_wready=1 while W latch empty.
  - AW and W may arrive in either order or together; each is latched at its handshake.
- IDLE, read acceptance: o_s_arready=1 only when both AW and W latches are empty and the grant allows reads.
- Arbitration: a write is "complete" when both latches are full.
  - If a complete write and ARVALID coexist in IDLE, the priority flag decides; the flag toggles after each granted contended access.
  - A partial write blocks reads (o_s_arready=0) until it completes, to prevent AXI reordering hazards.
- Write path (both latched, last latch at cycle T):
  - T+1 WR_ISSUE: o_m_ce=1, o_m_we=wstrb, o_m_addr/o_m_data_out from latches, for exactly one cycle.
  - T+2 WR_RESP: o_s_bvalid=1, held until i_s_bready; then latches clear and state returns to IDLE.
  - wstrb=0 still issues ce with we=0 (no-op) and responds.
- Read path (AR handshake at T):
  - T+1 RD_ISSUE: o_m_ce=1, o_m_we=0, o_m_addr set.
  - RD_WAIT counts READ_LATENCY cycles; o_m_addr stays stable through RD_ISSUE and RD_WAIT.
  - At the end of the last RD_WAIT cycle, i_m_data_in is registered into o_s_rdata.
  - RD_RESP: o_s_rvalid=1; o_s_rdata is held stable until i_s_rready, then IDLE. ARVALID to RVALID = READ_LATENCY+2 cycles.
- o_m_ce is high only in WR_ISSUE/RD_ISSUE; o_m_addr holds its last value otherwise.
- Backpressure: no new AW/W/AR is accepted while a B or R response is pending. One outstanding transaction total.
- Reset mid-transaction: immediate abort, no response issued, o_m_ce/o_m_we drop asynchronously.

Decomposition:
- Shared package holds:
  - AXI response codes (RESP_OKAY=2'b00).
  - FSM state encoding.
  - MMIO word-address constants (0x200-0x205), so firmware, this bridge's testbench and the memory wrapper agree.
- One natural sub-module: axil_wr_capture. It holds the independent AW/W holding registers, ready generation and the "write complete" flag. Read path and FSM stay in the top.

Test Plan:
- Write 0xDEADBEEF, strobe 0xF to byte addr 0x010 with AW and W together, then read 0x010 → o_m_addr=0x004, o_m_we=0xF for one cycle; BVALID two cycles after handshake; RDATA=0xDEADBEEF, RVALID exactly 3 cycles after AR.
- W arrives 4 cycles before AW at byte addr 0x80C (PWM width), data 0x7F → single ce pulse after AW, o_m_addr=0x203, BRESP=00.
- Read 0x800 (match count) with i_m_data_in driven 0x12345678 only while o_m_addr=0x200 → RDATA=0x12345678; o_m_addr constant from RD_ISSUE through capture.
- Complete write and ARVALID in the same cycle, twice in succession → first grant write, second read (priority toggle); no overlapping ce.
- RREADY held low 5 cycles → RVALID and RDATA stable; no AR/AW accepted until the handshake completes.
- Assert i_rst during RD_WAIT → rvalid/ce/we low asynchronously; after release a fresh read completes normally.
